// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response analyzer.
//   - state_t : analyzer sequencing states
//   - default geometry / signature constants
//   - cnt_w() : width of a counter that must hold 0..max
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int         CHAIN_LEN_D    = 8;
  localparam int         NUM_PATTERNS_D = 16;
  localparam int         SIG_W_D        = 8;
  localparam logic [7:0] SIG_POLY_D     = 8'h1D;
  localparam logic [7:0] SIG_SEED_D     = 8'h00;

  // Bits needed to count from 0 up to and including max (at least 1).
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register (Galois form, MSB out).
// Ports:
//   clk, rst  - clock, async active-high reset (to SIG_SEED)
//   load      - reload SIG_SEED (wins over shift)
//   shift     - compact din into the register
//   din       - serial response bit
//   sig       - current signature
//   sig_next  - value the register takes if shifted this cycle
module bist_sisr
  import bist_pkg::*;
#(
  parameter int               SIG_W    = SIG_W_D,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_D),
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SIG_SEED_D)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             din,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  // Feedback is the outgoing MSB xor the incoming bit, applied on the taps.
  assign sig_next = {sig[SIG_W-2:0], 1'b0}
                  ^ ({SIG_W{sig[SIG_W-1] ^ din}} & SIG_POLY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sig <= SIG_SEED;
    else if (load)  sig <= SIG_SEED;
    else if (shift) sig <= sig_next;
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST sequencer and response compactor sitting behind the scan chain.
// Steps the chain through load / capture / unload phases in lockstep with
// the shared d_clk strobe, compacts every unloaded bit into a SISR and
// compares the final signature to golden.
// Ports:
//   clk, rst    - clock, async active-high reset
//   d_clk       - one-cycle advance strobe shared with LFSR and chain
//   start       - one-cycle run request (honoured in IDLE/DONE only)
//   scan_out    - chain tail bit, sampled on d_clk edges
//   golden      - expected final signature
//   scan_en     - 1 = shift, 0 = capture
//   busy        - run in progress
//   done, pass  - run complete / signature matched (held until start/rst)
//   signature   - live SISR contents
//   pattern_cnt - patterns captured so far
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int               CHAIN_LEN    = CHAIN_LEN_D,
  parameter int               NUM_PATTERNS = NUM_PATTERNS_D,
  parameter int               SIG_W        = SIG_W_D,
  parameter logic [SIG_W-1:0] SIG_POLY     = SIG_W'(SIG_POLY_D),
  parameter logic [SIG_W-1:0] SIG_SEED     = SIG_W'(SIG_SEED_D),
  localparam int              PW           = cnt_w(NUM_PATTERNS),
  localparam int              BW           = cnt_w(CHAIN_LEN - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_clk,
  input  logic             start,
  input  logic             scan_out,
  input  logic [SIG_W-1:0] golden,
  output logic             scan_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [PW-1:0]    pattern_cnt
);

  state_t           state, state_d;
  logic [BW-1:0]    bit_cnt, bit_d;
  logic [PW-1:0]    pat_d;
  logic             done_d, pass_d;
  logic             sig_load, sig_shift;
  logic [SIG_W-1:0] sig_next;

  logic last_bit;
  assign last_bit = (bit_cnt == BW'(CHAIN_LEN - 1));

  bist_sisr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_SEED (SIG_SEED)
  ) u_sisr (
    .clk      (clk),
    .rst      (rst),
    .load     (sig_load),
    .shift    (sig_shift),
    .din      (scan_out),
    .sig      (signature),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      pattern_cnt <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_d;
      pattern_cnt <= pat_d;
      done        <= done_d;
      pass        <= pass_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_d     = bit_cnt;
    pat_d     = pattern_cnt;
    done_d    = done;
    pass_d    = pass;
    sig_load  = 1'b0;
    sig_shift = 1'b0;
    case (state)
      // start beats a coincident d_clk: that strobe is consumed by nothing.
      IDLE, DONE: begin
        if (start) begin
          state_d  = LOAD;
          bit_d    = '0;
          pat_d    = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          sig_load = 1'b1;
        end
      end
      // First fill: the chain holds no response yet, so nothing compacts.
      LOAD: begin
        if (d_clk) begin
          if (last_bit) begin
            state_d = CAPTURE;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + BW'(1);
          end
        end
      end
      CAPTURE: begin
        if (d_clk) begin
          pat_d   = pattern_cnt + PW'(1);
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (d_clk) begin
          sig_shift = 1'b1;
          if (last_bit) begin
            bit_d = '0;
            if (pattern_cnt == PW'(NUM_PATTERNS)) begin
              state_d = DONE;
              done_d  = 1'b1;
              // Compare the value being written this edge, not the stale one.
              pass_d  = (sig_next == golden);
            end else begin
              state_d = CAPTURE;
            end
          end else begin
            bit_d = bit_cnt + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_en = (state != CAPTURE);
  assign busy    = (state == LOAD) || (state == CAPTURE) || (state == UNLOAD);

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboard bench: stimulus pushes expected output snapshots into a queue,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_bist_response_analyzer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_clk = 1'b0;
  logic       start = 1'b0;
  logic       scan_out = 1'b0;
  logic [7:0] golden = 8'h00;
  logic       scan_en, busy, done, pass;
  logic [7:0] signature;
  logic [4:0] pattern_cnt;

  bist_response_analyzer dut (
    .clk         (clk),
    .rst         (rst),
    .d_clk       (d_clk),
    .start       (start),
    .scan_out    (scan_out),
    .golden      (golden),
    .scan_en     (scan_en),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature),
    .pattern_cnt (pattern_cnt)
  );

  always #5 clk = ~clk;

  // Field select mask: {scan_en, busy, done, pass, signature, pattern_cnt}
  localparam logic [5:0] M_SE  = 6'b100000;
  localparam logic [5:0] M_BZ  = 6'b010000;
  localparam logic [5:0] M_DN  = 6'b001000;
  localparam logic [5:0] M_PS  = 6'b000100;
  localparam logic [5:0] M_SG  = 6'b000010;
  localparam logic [5:0] M_PC  = 6'b000001;
  localparam logic [5:0] M_ALL = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [16:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [16:0] expand(input logic [5:0] m);
    return {m[5], m[4], m[3], m[2], {8{m[1]}}, {5{m[0]}}};
  endfunction

  task automatic expect_out(input string name, input logic [5:0] m,
                            input logic se, input logic bz, input logic dn,
                            input logic ps, input logic [7:0] sg,
                            input logic [4:0] pc);
    exp_t e;
    e.name = name;
    e.mask = m;
    e.val  = {se, bz, dn, ps, sg, pc};
    q.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle; check everything queued so far.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [16:0] act, msk;
      e   = q.pop_front();
      msk = expand(e.mask);
      act = {scan_en, busy, done, pass, signature, pattern_cnt};
      n_cmp++;
      if ((act & msk) !== (e.val & msk)) begin
        n_bad++;
        $display("FAIL %s: got {se,bz,dn,ps,sig,pc}=%h required %h (mask %h)",
                 e.name, act & msk, e.val & msk, msk);
      end
    end
  end

  // One d_clk strobe; returns just after the edge that consumed it.
  task automatic strobe(input logic so, input logic st);
    d_clk = 1'b1; scan_out = so; start = st;
    @(posedge clk); #1;
    d_clk = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Full 152-strobe run with scan_out=0; the SISR stays at 0 throughout.
  // golden is disturbed mid-run to show only the final strobe samples it.
  task automatic full_run(input string tag, input logic [7:0] gold,
                          input logic exp_pass);
    golden = gold;
    for (int n = 1; n <= 152; n++) begin
      if (n == 50)  golden = ~gold;
      if (n == 140) golden = gold;
      strobe(1'b0, 1'b0);
      if (n == 151)
        expect_out({tag, "_151"}, M_BZ | M_DN, 1, 1, 0, 0, 8'h00, 5'd0);
      if (n == 152)
        expect_out({tag, "_152"}, M_ALL, 1, 0, 1, exp_pass, 8'h00, 5'd16);
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    expect_out("reset", M_ALL, 1, 0, 0, 0, 8'h00, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    // Counting: start, then 8 load strobes
    do_start();
    expect_out("start", M_ALL, 1, 1, 0, 0, 8'h00, 5'd0);
    for (int i = 1; i <= 8; i++) begin
      strobe(1'b1, 1'b0);
      if (i == 7) expect_out("load7", M_SE | M_BZ, 1, 1, 0, 0, 8'h00, 5'd0);
    end
    expect_out("load8_capture", M_ALL, 0, 1, 0, 0, 8'h00, 5'd0);

    // Compaction
    strobe(1'b1, 1'b0);
    expect_out("captured1", M_SE | M_PC | M_SG, 1, 1, 0, 0, 8'h00, 5'd1);
    strobe(1'b1, 1'b0);
    expect_out("unload1", M_SG, 1, 1, 0, 0, 8'h1D, 5'd1);
    strobe(1'b1, 1'b0);
    expect_out("unload2", M_SG, 1, 1, 0, 0, 8'h27, 5'd1);
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
    expect_out("back_capture", M_SE | M_BZ | M_PC, 0, 1, 0, 0, 8'h00, 5'd1);

    // Reset mid-run during UNLOAD, pulsed strictly between clock edges
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    #2 rst = 1'b1;      // monitor samples at the falling edge while rst=1
    expect_out("rst_async", M_ALL, 1, 0, 0, 0, 8'h00, 5'd0);
    @(negedge clk); #1;
    rst = 1'b0;         // released before the next rising edge
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
    expect_out("rst_dclk_ignored", M_ALL, 1, 0, 0, 0, 8'h00, 5'd0);

    // Full run, matching golden
    do_start();
    full_run("run_pass", 8'h00, 1'b1);
    strobe(1'b1, 1'b0);
    expect_out("done_hold", M_ALL, 1, 0, 1, 1, 8'h00, 5'd16);

    // Restart from DONE, mismatching golden
    do_start();
    expect_out("restart", M_ALL, 1, 1, 0, 0, 8'h00, 5'd0);
    full_run("run_fail", 8'h01, 1'b0);

    // Collision of start and d_clk from IDLE
    do_reset();
    strobe(1'b1, 1'b1);
    expect_out("collide", M_ALL, 1, 1, 0, 0, 8'h00, 5'd0);
    for (int i = 1; i <= 8; i++) begin
      strobe(1'b1, 1'b0);
      if (i == 7) expect_out("collide_load7", M_SE, 1, 1, 0, 0, 8'h00, 5'd0);
    end
    expect_out("collide_capture", M_SE | M_BZ | M_PC, 0, 1, 0, 0, 8'h00, 5'd0);

    // Start while busy is ignored
    do_start();
    expect_out("start_busy", M_SE | M_BZ | M_PC, 0, 1, 0, 0, 8'h00, 5'd0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
